logic_unit_pipe: RTL
====================

# logic_unit_pipe

Parametrised, pipelined bitwise logic unit; next generation of the datapath's single-operation N-bit XOR. Adds an operation select (eight bitwise functions), a running XOR-fold accumulator for checksum/parity use, a configurable register pipeline and a valid/ready handshake on both sides. Sits in the ALU32 execute path as the logic-operation lane and in test/debug paths as a streaming XOR checksum engine.

## Interface
- N, 32: operand/result width in bits (N >= 1)
- STAGES, 2: pipeline register stages from accept to output (STAGES >= 1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  unit accepts beat this cycle
- op  input  3  operation select, see Operation
- A  input  N  operand A
- B  input  N  operand B
- in_last  input  1  final beat of an accumulate frame
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- Y  output  N  result
- out_last  output  1  in_last carried with the beat
- zero  output  1  Y == 0 for the presented beat

## Operation
- Accept = in_valid & in_ready. Result is computed combinationally at accept from op, A, B and the accumulator, then carried through STAGES registers with op-independent payload {Y, last, zero}.
- op encoding: 000 AND (A&B); 001 OR (A|B); 010 XOR (A^B); 011 NOR ~(A|B); 100 XNOR ~(A^B); 101 ANDN (A&~B); 110 ACCX (acc^A^B); 111 PASSA (A).
- Accumulator acc (N bits, resets to 0): on accept with op=ACCX, result = acc^A^B; acc <= result, or acc <= 0 when in_last=1 (frame closes, result is final checksum). Non-ACCX accepts never modify acc, even when in_last=1; in_last is still forwarded to out_last.
- zero computed at accept on the result, stored with the beat.
- Pipeline: valid bit per stage. Global advance = ~valid[STAGES-1] | out_ready. When advance=1 every stage shifts one step; when 0 all stages hold. Bubbles are not compressed.
- in_ready = advance (combinational from out_ready and last-stage valid). in_valid may depend on in_ready; out_ready must not depend on out_valid combinationally from this block's inputs (no loop introduced here).
- Output stage: out_valid = valid[STAGES-1]; Y, out_last, zero driven from last stage registers; held stable while out_valid & ~out_ready.

## Timing
- Reset (async assert, sync release): all valid bits 0, acc 0, all payload registers 0, so out_valid=0, Y=0, out_last=0, zero=0. in_ready=1 from first cycle after reset.
- Latency: beat accepted at edge k appears with out_valid=1 after edge k+STAGES-1 (visible in cycle k+STAGES), given no stall.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_ready=0 with output valid freezes entire pipe and acc; in_ready=0 same cycle; no beat lost or duplicated.
- Simultaneous output handshake and input accept in one cycle: both take effect; full pipe sustains rate.
- Reset mid-frame: acc and in-flight beats discarded; next ACCX starts from 0.
- Back-to-back ACCX beats: second uses acc updated by first (acc update is at accept, not at output).
- Width: all operations N-bit, no carry; ~ applied at width N.

## Structure
- Shared package logic_pkg: typedef enum logic [2:0] logic_op_t {LOP_AND, LOP_OR, LOP_XOR, LOP_NOR, LOP_XNOR, LOP_ANDN, LOP_ACCX, LOP_PASSA}; reused by ALU decode.
- One sub-module natural: logic_op_comb (parametrised N, purely combinational op mux incl. ACCX term); top holds acc, valid shift and payload registers (generate loop over STAGES).

## Test plan
- Reset then N=32, STAGES=2: A=F0F0_F0F0, B=FF00_FF00, ops 000..101,111 back-to-back, out_ready=1 -> Y = F000_F000, FFF0_FFF0, 0FF0_0FF0, 000F_000F, F00F_F00F, 00F0_00F0, F0F0_F0F0, each 2 cycles after accept, one per cycle.
- ACCX frame: (A,B) = (0000_0001,0), (0000_0002,0), (0000_0004,0) last=1 -> Y = 1, 3, 7; out_last only on third; following ACCX (8,0) -> Y=8 (acc cleared).
- Backpressure: stream 6 XOR beats, out_ready low for cycles 3-6 -> in_ready low same cycles, Y held stable, all 6 results delivered in order, none duplicated.
- zero flag: XOR A=B=DEAD_BEEF -> Y=0, zero=1; NOR A=B=FFFF_FFFF -> zero=1; AND 1,1 -> zero=0.
- Async reset asserted mid-frame with 2 beats in flight -> out_valid=0, Y=0 immediately; next ACCX (5,0) -> Y=5.
- Parameter sweep N=1/STAGES=1 and N=64/STAGES=4: latency = STAGES cycles, XNOR of all-zero operands yields all-ones of width N.

Source files
------------

// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the bitwise logic lane: operation encoding reused by ALU decode.
package logic_pkg;

  typedef enum logic [2:0] {
    LOP_AND   = 3'b000,
    LOP_OR    = 3'b001,
    LOP_XOR   = 3'b010,
    LOP_NOR   = 3'b011,
    LOP_XNOR  = 3'b100,
    LOP_ANDN  = 3'b101,
    LOP_ACCX  = 3'b110,
    LOP_PASSA = 3'b111
  } logic_op_t;

  localparam int LOP_WIDTH = 3;

  function automatic logic is_accumulate(input logic_op_t op);
    return op == LOP_ACCX;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result stream bundle for logic_unit_pipe: input beat side plus output beat side.
interface logic_unit_pipe_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Y;
  logic         out_last;
  logic         zero;

  modport master (
    output in_valid, op, A, B, in_last, out_ready,
    input  in_ready, out_valid, Y, out_last, zero
  );

  modport slave (
    input  in_valid, op, A, B, in_last, out_ready,
    output in_ready, out_valid, Y, out_last, zero
  );
endinterface

// File: rtl/logic_unit_pipe_op_comb.sv
// Purely combinational operation mux; the ACCX term folds the running accumulator in.
module logic_op_comb
  import logic_pkg::*;
#(
  parameter int N = 32
) (
  input  logic_op_t    op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] acc,
  output logic [N-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      LOP_AND:   y = a & b;
      LOP_OR:    y = a | b;
      LOP_XOR:   y = a ^ b;
      LOP_NOR:   y = ~(a | b);
      LOP_XNOR:  y = ~(a ^ b);
      LOP_ANDN:  y = a & ~b;
      LOP_ACCX:  y = acc ^ a ^ b;
      LOP_PASSA: y = a;
      default:   y = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with XOR-fold accumulator and a globally stalled register pipe.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave bus
);

  logic_op_t         op_sel;
  logic [N-1:0]      acc_reg;
  logic [N-1:0]      result;
  logic              result_zero;
  logic              advance;
  logic              accept;

  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] last_reg;
  logic [STAGES-1:0] zero_reg;
  logic [N-1:0]      y_reg  [STAGES];

  logic [STAGES-1:0] valid_next;
  logic [STAGES-1:0] last_next;
  logic [STAGES-1:0] zero_next;
  logic [N-1:0]      y_next [STAGES];

  assign op_sel      = logic_op_t'(bus.op);
  // Whole pipe moves together; a bubble in the last stage lets everything shift.
  assign advance     = ~valid_reg[STAGES-1] | bus.out_ready;
  assign accept      = bus.in_valid & advance;
  assign result_zero = (result == '0);

  logic_op_comb #(.N(N)) u_op_comb (
    .op  (op_sel),
    .a   (bus.A),
    .b   (bus.B),
    .acc (acc_reg),
    .y   (result)
  );

  // The accumulator updates at accept so back-to-back ACCX beats chain correctly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (accept && is_accumulate(op_sel)) begin
      acc_reg <= bus.in_last ? '0 : result;
    end
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage_in
      if (gi == 0) begin : g_head
        assign valid_next[gi] = accept;
        assign last_next[gi]  = bus.in_last;
        assign zero_next[gi]  = result_zero;
        assign y_next[gi]     = result;
      end else begin : g_body
        assign valid_next[gi] = valid_reg[gi-1];
        assign last_next[gi]  = last_reg[gi-1];
        assign zero_next[gi]  = zero_reg[gi-1];
        assign y_next[gi]     = y_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      last_reg  <= '0;
      zero_reg  <= '0;
      y_reg     <= '{default: '0};
    end else if (advance) begin
      valid_reg <= valid_next;
      last_reg  <= last_next;
      zero_reg  <= zero_next;
      y_reg     <= y_next;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_reg[STAGES-1];
  assign bus.Y         = y_reg[STAGES-1];
  assign bus.out_last  = last_reg[STAGES-1];
  assign bus.zero      = zero_reg[STAGES-1];

endmodule
